reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 173 +++++++++++++++++
 tb/tb_reg_file_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: scoreboarded register file with two combinational read ports,
// one write port and one reservation port. After reset a one-entry-per-cycle
// sweep zeroes the array (CLEAR); the block then accepts traffic (RUN).
// Register 0 and indices >= NREGS read as zero and ignore writes and
// reservations.

// One architectural register: data word plus its "result pending" bit.
module reg_file_sb_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            wr_i,
  input  logic            rsv_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            pend_o
);

  logic [XLEN-1:0] data_q;
  logic            pend_q;

  // Data has no reset of its own; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (clr_i)
      data_q <= '0;
    else if (wr_i)
      data_q <= wdata_i;
  end

  // Pending: a same-cycle reservation beats the clearing write.
  always_ff @(posedge clk) begin
    if (!rst)
      pend_q <= 1'b0;
    else if (rsv_i)
      pend_q <= 1'b1;
    else if (wr_i)
      pend_q <= 1'b0;
  end

  assign data_o = data_q;
  assign pend_o = pend_q;

endmodule

module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   src1_reg,
  input  logic [AW-1:0]   src2_reg,
  output logic [XLEN-1:0] src1_reg_value,
  output logic [XLEN-1:0] src2_reg_value,
  output logic            src1_pending,
  output logic            src2_pending,
  input  logic [AW-1:0]   dest_reg,
  input  logic [XLEN-1:0] reg_write_data,
  input  logic            reg_write_control,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_reg,
  output logic            ready
);

  // Decode space is padded to a power of two so any index value selects a
  // defined entry; the padding entries are tied to zero.
  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   NREGS_X  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q;

  logic            run;
  logic            sweep;
  logic            wr_ok;
  logic            rsv_ok;

  logic [DEPTH-1:0][XLEN-1:0] ent_data;
  logic [DEPTH-1:0]           ent_pend;

  logic wr_hit1, wr_hit2, rsv_hit1, rsv_hit2;

  // Index is a real architectural register (nonzero and below NREGS).
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NREGS_X);
  endfunction

  // State, sweep pointer and registered ready; reset restarts the sweep at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == RUN);
    end
  end

  // Next state: walk clr_idx up to the last register, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX)
          state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign run    = (state_q == RUN);
  assign sweep  = (state_q == CLEAR) && rst;
  assign wr_ok  = run && reg_write_control && idx_ok(dest_reg);
  assign rsv_ok = run && rsv_en && idx_ok(rsv_reg);
  assign ready  = ready_q;

  // One storage entry per legal register; x0 and out-of-range slots are zero.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    if (g == 0 || g >= NREGS) begin : g_tie
      assign ent_data[g] = '0;
      assign ent_pend[g] = 1'b0;
    end else begin : g_reg
      reg_file_sb_entry #(.XLEN(XLEN)) u_ent (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sweep  && (clr_idx_q == AW'(g))),
        .wr_i    (wr_ok  && (dest_reg  == AW'(g))),
        .rsv_i   (rsv_ok && (rsv_reg   == AW'(g))),
        .wdata_i (reg_write_data),
        .data_o  (ent_data[g]),
        .pend_o  (ent_pend[g])
      );
    end
  end

  // Same-cycle hits used for write-first bypass and pending override.
  assign wr_hit1  = wr_ok  && (dest_reg == src1_reg);
  assign wr_hit2  = wr_ok  && (dest_reg == src2_reg);
  assign rsv_hit1 = rsv_ok && (rsv_reg  == src1_reg);
  assign rsv_hit2 = rsv_ok && (rsv_reg  == src2_reg);

  // Read ports: zero outside RUN, write data bypassed, else stored value.
  always_comb begin
    src1_reg_value = '0;
    src2_reg_value = '0;
    src1_pending   = 1'b0;
    src2_pending   = 1'b0;
    if (run) begin
      src1_reg_value = wr_hit1 ? reg_write_data : ent_data[src1_reg];
      src2_reg_value = wr_hit2 ? reg_write_data : ent_data[src2_reg];
      // A completing write hides the pending bit unless it is re-reserved
      // this cycle; reservations themselves only show up next cycle.
      src1_pending   = ent_pend[src1_reg] && !(wr_hit1 && !rsv_hit1);
      src2_pending   = ent_pend[src2_reg] && !(wr_hit2 && !rsv_hit2);
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (NREGS=32 and NREGS=20) share stimulus;
// a behavioural model queues expected outputs, a negedge monitor checks them.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [AW-1:0]   src1_reg, src2_reg, dest_reg, rsv_reg;
  logic [XLEN-1:0] reg_write_data;
  logic            reg_write_control, rsv_en;

  logic [1:0]           rdy_o, p1_o, p2_o;
  logic [1:0][XLEN-1:0] v1_o, v2_o;

  reg_file_sb #(.XLEN(XLEN), .NREGS(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_reg_value(v1_o[0]), .src2_reg_value(v2_o[0]),
    .src1_pending(p1_o[0]), .src2_pending(p2_o[0]),
    .dest_reg(dest_reg), .reg_write_data(reg_write_data),
    .reg_write_control(reg_write_control),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .ready(rdy_o[0])
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(20)) u_dut20 (
    .clk(clk), .rst(rst),
    .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_reg_value(v1_o[1]), .src2_reg_value(v2_o[1]),
    .src1_pending(p1_o[1]), .src2_pending(p2_o[1]),
    .dest_reg(dest_reg), .reg_write_data(reg_write_data),
    .reg_write_control(reg_write_control),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .ready(rdy_o[1])
  );

  typedef struct {
    int          inst;
    logic        rdy;
    logic [31:0] v1, v2;
    logic        p1, p2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: register contents, pending flags, sweep countdown.
  int          nr     [2];
  logic [31:0] m_reg  [2][64];
  bit          m_pend [2][64];
  bit          m_run  [2];
  bit          m_known[2];
  int          m_left [2];

  function automatic bit legal(int k, int idx);
    return (idx != 0) && (idx < nr[k]);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, got, exp);
    end
  endtask

  // Monitor: pop every expectation queued for this cycle and compare.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready",   e.inst, 32'(rdy_o[e.inst]), 32'(e.rdy));
      chk("src1_val", e.inst, v1_o[e.inst], e.v1);
      chk("src2_val", e.inst, v2_o[e.inst], e.v2);
      chk("src1_pend", e.inst, 32'(p1_o[e.inst]), 32'(e.p1));
      chk("src2_pend", e.inst, 32'(p2_o[e.inst]), 32'(e.p2));
    end
  end

  // One clock: drive inputs, queue expectations, advance the model at the edge.
  task automatic step(input bit r, input int s1, input int s2, input int d,
                      input logic [31:0] wd, input bit we, input bit re,
                      input int rv);
    rst               = r;
    src1_reg          = s1[AW-1:0];
    src2_reg          = s2[AW-1:0];
    dest_reg          = d[AW-1:0];
    reg_write_data    = wd;
    reg_write_control = we;
    rsv_en            = re;
    rsv_reg           = rv[AW-1:0];
    for (int k = 0; k < 2; k++) begin
      if (m_known[k]) begin
        exp_t e;
        bit wl, rl;
        wl = we && legal(k, d);
        rl = re && legal(k, rv);
        e.inst = k;
        e.rdy  = m_run[k];
        e.v1 = '0; e.v2 = '0; e.p1 = 1'b0; e.p2 = 1'b0;
        if (m_run[k]) begin
          e.v1 = (wl && d == s1) ? wd : m_reg[k][s1];
          e.v2 = (wl && d == s2) ? wd : m_reg[k][s2];
          e.p1 = m_pend[k][s1] && !(wl && d == s1 && !(rl && rv == s1));
          e.p2 = m_pend[k][s2] && !(wl && d == s2 && !(rl && rv == s2));
        end
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_known[k] = 1'b1;
        m_run[k]   = 1'b0;
        m_left[k]  = nr[k] - 1;
        for (int i = 0; i < 64; i++) begin
          m_reg[k][i]  = '0;
          m_pend[k][i] = 1'b0;
        end
      end else if (m_known[k] && !m_run[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) m_run[k] = 1'b1;
      end else if (m_known[k]) begin
        if (we && legal(k, d)) begin
          m_reg[k][d]  = wd;
          m_pend[k][d] = 1'b0;
        end
        if (re && legal(k, rv)) m_pend[k][rv] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int s1, input int s2);
    step(1'b1, s1, s2, 0, 32'h0, 1'b0, 1'b0, 0);
  endtask

  function automatic int pick();
    return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(5, 9));
  endfunction

  initial begin
    nr[0] = 32; nr[1] = 20;
    m_known[0] = 1'b0; m_known[1] = 1'b0;
    m_run[0] = 1'b0; m_run[1] = 1'b0;
    rst = 1'b0; src1_reg = '0; src2_reg = '0; dest_reg = '0; rsv_reg = '0;
    reg_write_data = '0; reg_write_control = 1'b0; rsv_en = 1'b0;
    #1;

    // Reset held two cycles, then sweep; writes/reservations during sweep ignored.
    step(1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    step(1'b0, 3, 4, 0, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 34; i++)
      step(1'b1, 5, 7, 5, 32'h1111_0000 + i, 1'b1, 1'b1, 7);
    for (int i = 0; i < 32; i++) idle(i, 31 - i);

    // Write-first bypass then stored value.
    step(1'b1, 5, 0, 5, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    idle(5, 5);

    // Reserve then complete x7.
    step(1'b1, 0, 7, 0, 32'h0, 1'b0, 1'b1, 7);
    idle(0, 7);
    step(1'b1, 7, 7, 7, 32'h12, 1'b1, 1'b0, 0);
    idle(7, 7);
    idle(7, 7);

    // Write+reserve same index; x0 ignores both.
    step(1'b1, 9, 9, 9, 32'h55, 1'b1, 1'b1, 9);
    idle(9, 9);
    step(1'b1, 0, 9, 0, 32'h77, 1'b1, 1'b1, 0);
    idle(0, 0);

    // Out-of-range index on the NREGS=20 instance; no aliasing.
    step(1'b1, 4, 0, 4, 32'h44, 1'b1, 1'b0, 0);
    step(1'b1, 25, 4, 25, 32'hAAAA, 1'b1, 1'b1, 25);
    idle(25, 4);
    idle(9, 5);
    idle(25, 25);

    // Reset pulse mid-sweep at sweep cycle 10.
    step(1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) idle(3, 9);
    step(1'b0, 3, 9, 0, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 33; i++) idle(3, 9);

    // Reset pulse in RUN with x3 pending.
    step(1'b1, 3, 3, 3, 32'h33, 1'b1, 1'b0, 0);
    step(1'b1, 3, 3, 0, 32'h0, 1'b0, 1'b1, 3);
    idle(3, 3);
    step(1'b0, 3, 3, 0, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 33; i++) idle(3, 3);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 249) != 0), pick(), pick(), pick(), $urandom(),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), pick());
    end
    for (int i = 0; i < 34; i++) idle(pick(), pick());

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
